// File: rtl/lane_stream_mux_pkg.sv
// Shared definitions for the lane stream multiplexer family: mode encodings
// and a constant-evaluable ceil(log2) helper for sizing index ports.
package lane_stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester found scanning from ptr
// upward with wrap, for any channel count (not just powers of two).
module rr_arbiter
  import lane_stream_mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic [SEL_W-1:0]    grant_o,
  output logic                grant_valid_o
);

  always_comb begin
    int unsigned idx;
    idx           = 0;
    grant_o       = '0;
    grant_valid_o = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      // Explicit wrap compare keeps non-power-of-two channel counts correct.
      idx = 32'(ptr_i) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_valid_o && req_i[idx]) begin
        grant_o       = SEL_W'(idx);
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_stream_mux.sv
// Multiplexes CHANNELS valid/ready input streams onto one registered output,
// with fixed-select or round-robin channel choice selected at run time.
module lane_stream_mux
  import lane_stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             is_rr;
  logic             fix_valid;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             xfer;

  rr_arbiter #(
    .CHANNELS(CHANNELS),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req_i        (in_valid),
    .ptr_i        (ptr_q),
    .grant_o      (rr_grant),
    .grant_valid_o(rr_valid)
  );

  always_comb begin
    load        = !out_valid_q || out_ready;
    is_rr       = (mode_e'(mode) == MODE_RR);
    fix_valid   = (32'(sel) < CHANNELS) && in_valid[sel];
    grant       = is_rr ? rr_grant : sel;
    grant_valid = is_rr ? rr_valid : fix_valid;
    // A grant always implies the granted channel is valid, so load+grant is a transfer.
    xfer        = load && grant_valid && !rst;
    in_ready    = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = in_data[grant*WIDTH +: WIDTH];
      out_ch_d   = grant;
      if (is_rr) ptr_d = (32'(grant) + 32'd1 == CHANNELS) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_lane_stream_mux.sv
// Directed bench for lane_stream_mux: a 4-channel and a 3-channel instance.
module tb_lane_stream_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mode4 = 1'b0;
  logic [1:0]  sel4 = '0;
  logic [3:0]  iv4 = '0;
  logic [15:0] id4 = '0;
  logic [3:0]  ir4;
  logic        ov4;
  logic [3:0]  od4;
  logic [1:0]  oc4;
  logic        ordy4 = 1'b0;

  logic        mode3 = 1'b0;
  logic [1:0]  sel3 = '0;
  logic [2:0]  iv3 = '0;
  logic [11:0] id3 = '0;
  logic [2:0]  ir3;
  logic        ov3;
  logic [3:0]  od3;
  logic [1:0]  oc3;
  logic        ordy3 = 1'b0;

  int unsigned passed = 0;
  int unsigned total  = 0;

  lane_stream_mux #(.WIDTH(4), .CHANNELS(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .sel(sel4), .in_valid(iv4),
    .in_data(id4), .in_ready(ir4), .out_valid(ov4), .out_data(od4),
    .out_ch(oc4), .out_ready(ordy4)
  );

  lane_stream_mux #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_valid(iv3),
    .in_data(id3), .in_ready(ir3), .out_valid(ov3), .out_data(od3),
    .out_ch(oc3), .out_ready(ordy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_ch [5];
    logic [3:0] exp_dat[5];

    // Reset state, with valids asserted to show in_ready stays low in reset
    iv4 = 4'b1111;
    #1;
    chk("rst_ov", 32'(ov4), 32'd0);
    chk("rst_od", 32'(od4), 32'd0);
    chk("rst_oc", 32'(oc4), 32'd0);
    chk("rst_ir", 32'(ir4), 32'd0);
    tick();
    iv4 = '0;
    rst = 1'b0;
    #1;
    chk("idle_ir", 32'(ir4), 32'd0);
    chk("idle_ir3", 32'(ir3), 32'd0);

    // Fixed select sel=2
    id4   = 16'hCA51;
    mode4 = 1'b0;
    sel4  = 2'd2;
    iv4   = 4'b1111;
    ordy4 = 1'b1;
    #1;
    chk("fix_ir", 32'(ir4), 32'h4);
    tick();
    chk("fix_ov", 32'(ov4), 32'd1);
    chk("fix_od", 32'(od4), 32'hA);
    chk("fix_oc", 32'(oc4), 32'd2);
    chk("fix_ir2", 32'(ir4), 32'h4);

    // Round robin, all valid, ptr=0 (fixed mode left it untouched)
    mode4 = 1'b1;
    #1;
    chk("rr_ir0", 32'(ir4), 32'h1);
    exp_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_dat = '{4'h1, 4'h5, 4'hA, 4'hC, 4'h1};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_ov", 32'(ov4), 32'd1);
      chk("rr_oc", 32'(oc4), 32'(exp_ch[i]));
      chk("rr_od", 32'(od4), 32'(exp_dat[i]));
    end

    // Mid-stream reset: out_valid drops without a clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_ov", 32'(ov4), 32'd0);
    chk("mrst_ir", 32'(ir4), 32'd0);
    iv4 = '0;
    rst = 1'b0;
    #1;
    chk("mrst_idle", 32'(ir4), 32'd0);
    tick();

    // Round-robin skip, ptr=0
    iv4 = 4'b1010;
    #1;
    chk("skip_ir0", 32'(ir4), 32'h2);
    tick();
    chk("skip_oc0", 32'(oc4), 32'd1);
    chk("skip_od0", 32'(od4), 32'h5);
    chk("skip_ir1", 32'(ir4), 32'h8);
    tick();
    chk("skip_oc1", 32'(oc4), 32'd3);
    chk("skip_od1", 32'(od4), 32'hC);
    chk("skip_ir2", 32'(ir4), 32'h2);
    tick();
    chk("skip_oc2", 32'(oc4), 32'd1);
    chk("skip_ptr2", 32'(ir4), 32'h8);

    // Backpressure for 3 cycles
    ordy4 = 1'b0;
    #1;
    chk("bp_ir", 32'(ir4), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ov", 32'(ov4), 32'd1);
      chk("bp_od", 32'(od4), 32'h5);
      chk("bp_oc", 32'(oc4), 32'd1);
      chk("bp_ir_hold", 32'(ir4), 32'd0);
    end
    ordy4 = 1'b1;
    #1;
    chk("bp_rel_ir", 32'(ir4), 32'h8);
    tick();
    chk("bp_next_oc", 32'(oc4), 32'd3);
    chk("bp_next_od", 32'(od4), 32'hC);
    tick();
    chk("bp_next2_oc", 32'(oc4), 32'd1);

    // Drain with no input: out_valid falls
    iv4 = '0;
    tick();
    chk("drain_ov", 32'(ov4), 32'd0);
    chk("drain_ir", 32'(ir4), 32'd0);

    // Fixed select on an idle channel gives no grant
    mode4 = 1'b0;
    sel4  = 2'd1;
    iv4   = 4'b1101;
    #1;
    chk("fix_nogrant", 32'(ir4), 32'd0);
    tick();
    chk("fix_nogrant_ov", 32'(ov4), 32'd0);
    iv4 = '0;

    // Three channels: out-of-range sel, then round-robin wrap
    id3   = 12'h963;
    mode3 = 1'b0;
    sel3  = 2'd3;
    iv3   = 3'b111;
    ordy3 = 1'b1;
    #1;
    chk("c3_oor_ir", 32'(ir3), 32'd0);
    tick();
    chk("c3_oor_ov", 32'(ov3), 32'd0);
    mode3 = 1'b1;
    #1;
    chk("c3_rr_ir", 32'(ir3), 32'h1);
    exp_ch  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    exp_dat = '{4'h3, 4'h6, 4'h9, 4'h3, 4'h6};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c3_rr_ov", 32'(ov3), 32'd1);
      chk("c3_rr_oc", 32'(oc3), 32'(exp_ch[i]));
      chk("c3_rr_od", 32'(od3), 32'(exp_dat[i]));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lane_stream_mux.md
Name: lane_stream_mux

Overview:
- Parametrised successor to the 4-lane, 4-bit combinational selector.
- Multiplexes CHANNELS input streams of WIDTH bits (for example, per-lane note/key codes) onto one registered output stream.
- Every port uses valid/ready handshaking.
- Two run-time modes: fixed select (sel, like the old S input) or round-robin arbitration, so no lane starves when several lanes assert together.

Parameters:
- WIDTH, 4: data bits per channel.
- CHANNELS, 4: number of input channels, 2..16.
- SEL_W, $clog2(CHANNELS): width of sel and out_ch.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_valid  input  CHANNELS  per-channel valid.
- in_data  input  CHANNELS*WIDTH  packed data; channel i occupies [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  per-channel ready, one-hot or zero.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts.

Behaviour:
- Clock and reset are fixed: one clock, clk; asynchronous active-high reset, rst.
- Reset values: out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0.
  - in_ready is all-zero while rst is asserted.
- load = !out_valid || out_ready. The output register may take new data this cycle.
- Grant (combinational):
  - mode=0: grant=sel when sel<CHANNELS and in_valid[sel]=1; otherwise no grant.
  - mode=1: grant is the first i with in_valid[i]=1, scanning ptr, ptr+1, … with wrap modulo CHANNELS; no grant if in_valid is all zero.
- in_ready[i] = load && granted && grant==i.
  - At most one bit is set.
  - in_ready never depends on in_valid of the same channel beyond the grant scan.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
- If load=1 and no transfer, out_valid <= 0 at the next edge.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 transfer per cycle while out_ready=1.
- Backpressure: while out_valid=1 && out_ready=0, out_data and out_ch hold stable and all in_ready=0.
- Pointer update: ptr <= (g+1) mod CHANNELS.
  - Updates only on a transfer in mode=1.
  - No update in mode=0.
  - No update on a cycle with no transfer.
- Mode or sel changes take effect on the same cycle's grant (both are combinational inputs). ptr is retained across mode changes.
- Simultaneous output drain and new input (out_valid=1, out_ready=1, transfer): the register is replaced, with no bubble.
- Reset mid-operation: the held word is discarded immediately (out_valid=0 asynchronously) and ptr returns to 0.
- Non-power-of-two CHANNELS: out-of-range sel produces no grant; the pointer wrap uses an explicit compare, not bit truncation.

Decomposition:
- Shared package/header holds:
  - the mode encodings MODE_FIXED=0 and MODE_RR=1;
  - the clog2 helper function.
- One natural sub-module: rr_arbiter.
  - Inputs: req[CHANNELS], ptr.
  - Outputs: grant index and grant_valid.
  - Purely combinational; reusable by other lane blocks.
- Output register and pointer state stay in lane_stream_mux.

Test Plan:
- Reset and idle: assert rst mid-stream while out_valid=1 → out_valid=0 immediately; after release, all in_ready=0 until some in_valid is set; ptr=0.
- Fixed mode, mode=0, sel=2, in_valid=4'b1111, in_data ch2=4'hA, out_ready=1:
  - in_ready=4'b0100;
  - next cycle out_data=4'hA, out_ch=2;
  - ch0, ch1 and ch3 never get ready.
- Round-robin fairness, mode=1, all four valid continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,1…, with one word per cycle.
- Round-robin skip: in_valid=4'b1010, ptr=0 → grant ch1, then ch3, then ch1; ptr ends at 2 after the ch1 grant.
- Backpressure: out_valid=1 with out_ready held 0 for 3 cycles → out_data and out_ch stable, in_ready=0. Release → the next word follows with no bubble and no duplicate.
- Non-power-of-two: CHANNELS=3, mode=0, sel=3 → no grant and out_valid stays 0. In mode=1 with all valid, out_ch sequence 0,1,2,0.
